fir_transposed_param: RTL

- Parametrised next-generation transposed-form FIR filter with runtime-loadable, double-buffered coefficient bank, valid-qualified sample flow, and rounded/saturated output scaling.
- Sits between the sample source (DIN_W-bit samples, 12 MHz domain) and downstream processing.
- Replaces fixed 33-tap, 16-bit, no-scaling transposed filter instances.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_round_sat.sv | 42 ++++
 rtl/fir_transposed_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and helpers for the FIR filter family.
// Saturation limits are derived from the output width so every variant clips identically.
package fir_pkg;
    localparam int TAPS_DEF   = 33;
    localparam int DIN_W_DEF  = 3;
    localparam int COEF_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int DOUT_W_DEF = 16;
    localparam int SHIFT_W    = 5;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic longint sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam longint SAT_HI_DEF = sat_hi(DOUT_W_DEF);
    localparam longint SAT_LO_DEF = sat_lo(DOUT_W_DEF);
endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up arithmetic right shift followed by saturation to DOUT_W.
// Shift amounts past the accumulator width clamp to ACC_W-1.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF
) (
    input  logic signed [ACC_W-1:0]   i_y,
    input  logic        [SHIFT_W-1:0] i_shift,
    output logic signed [DOUT_W-1:0]  o_r,
    output logic                      o_clip
);
    localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(sat_hi(DOUT_W));
    localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(sat_lo(DOUT_W));

    logic        [SHIFT_W-1:0] w_s;
    logic signed [ACC_W:0]     w_ext;
    logic signed [ACC_W:0]     w_bias;
    logic signed [ACC_W:0]     w_sh;
    logic                      w_hi;
    logic                      w_lo;

    always_comb begin
        w_s    = (int'(i_shift) >= ACC_W) ? SHIFT_W'(ACC_W - 1) : i_shift;
        // one guard bit keeps y + 2^(s-1) from wrapping
        w_ext  = {i_y[ACC_W-1], i_y};
        w_bias = '0;
        if (w_s != '0)
            w_bias = (ACC_W+1)'(1) << (w_s - SHIFT_W'(1));
        w_sh   = (w_ext + w_bias) >>> w_s;
        w_hi   = (w_sh > HI);
        w_lo   = (w_sh < LO);
        o_clip = w_hi || w_lo;
        if (w_hi)
            o_r = DOUT_W'(HI);
        else if (w_lo)
            o_r = DOUT_W'(LO);
        else
            o_r = w_sh[DOUT_W-1:0];
    end
endmodule

// File: rtl/fir_transposed_param.sv
// Transposed-form FIR with double-buffered runtime coefficients and rounded/saturated output.
// Output is registered on the sample edge; oFirValid pulses once per accepted sample.
module fir_transposed_param
    import fir_pkg::*;
#(
    parameter int TAPS            = TAPS_DEF,
    parameter int DIN_W           = DIN_W_DEF,
    parameter int COEF_W          = COEF_W_DEF,
    parameter int ACC_W           = ACC_W_DEF,
    parameter int DOUT_W          = DOUT_W_DEF,
    parameter int FLUSH_ON_COMMIT = 0,
    localparam int AW             = clog2(TAPS)
) (
    input  logic                      iClk_12M,
    input  logic                      iRst,
    input  logic                      iEnSample,
    input  logic signed [DIN_W-1:0]   iFirIn,
    input  logic                      iCoefWe,
    input  logic        [AW-1:0]      iCoefAddr,
    input  logic signed [COEF_W-1:0]  iCoefData,
    input  logic                      iCoefCommit,
    input  logic        [SHIFT_W-1:0] iShiftAmt,
    input  logic                      iSatClr,
    output logic signed [DOUT_W-1:0]  oFirOut,
    output logic                      oFirValid,
    output logic                      oSat
);
    logic [TAPS-1:0][COEF_W-1:0] r_shadow;
    logic [TAPS-1:0][COEF_W-1:0] r_coef;
    logic [TAPS-1:1][ACC_W-1:0]  r_z;
    logic [TAPS-1:1][ACC_W-1:0]  w_znext;
    logic [TAPS-1:0][ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]     w_y;
    logic signed [DOUT_W-1:0]    w_r;
    logic                        w_clip;
    logic                        w_flush;
    logic signed [DOUT_W-1:0]    r_out;
    logic                        r_valid;
    logic                        r_sat;

    // Full-precision products, sign-extended to the accumulator width
    for (genvar k = 0; k < TAPS; k++) begin : g_prod
        assign w_prod[k] = ACC_W'($signed(iFirIn)) * ACC_W'($signed(r_coef[k]));
    end

    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        if (k == TAPS - 1) begin : g_last
            assign w_znext[k] = w_prod[k];
        end else begin : g_mid
            assign w_znext[k] = r_z[k+1] + w_prod[k];
        end
    end

    assign w_y     = w_prod[0] + r_z[1];
    assign w_flush = (FLUSH_ON_COMMIT != 0) && iCoefCommit;

    fir_round_sat #(
        .ACC_W  (ACC_W),
        .DOUT_W (DOUT_W)
    ) u_round_sat (
        .i_y     (w_y),
        .i_shift (iShiftAmt),
        .o_r     (w_r),
        .o_clip  (w_clip)
    );

    // Commit copies the shadow as it stood before any coinciding write
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            r_shadow <= '0;
            r_coef   <= '0;
        end else begin
            if (iCoefCommit)
                r_coef <= r_shadow;
            if (iCoefWe && (int'(iCoefAddr) < TAPS))
                r_shadow[iCoefAddr] <= iCoefData;
        end
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst)
            r_z <= '0;
        else if (w_flush)
            r_z <= '0;
        else if (iEnSample)
            r_z <= w_znext;
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= iEnSample;
            if (iEnSample)
                r_out <= w_r;
            if (iEnSample && w_clip)
                r_sat <= 1'b1;
            else if (iSatClr)
                r_sat <= 1'b0;
        end
    end

    assign oFirOut   = r_out;
    assign oFirValid = r_valid;
    assign oSat      = r_sat;
endmodule
